// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encodings, opcodes,
// mux-select codes and the decoded control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StRwb    = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] SrcBReg      = 2'b00;
  localparam logic [1:0] SrcBFour     = 2'b01;
  localparam logic [1:0] SrcBImm      = 2'b10;
  localparam logic [1:0] SrcBImmShift = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, control word out.
interface multicycle_control_if;
  import mips_ctrl_pkg::*;

  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;

  // Controller side.
  modport master (
    input  op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
    output MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
    output state, instr_done, illegal_op
  );

  // Datapath side.
  modport slave (
    output op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
    input  MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
    input  state, instr_done, illegal_op
  );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational state + mem_ready -> control word. Opcode-dependent outputs
// (illegal_op) are added by the parent.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SrcBFour;
        ctrl.alu_op    = AluOpAdd;
        ctrl.pc_source = PcSrcAlu;
        // PC+4 and IR load only once the fetch read actually returns.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b = SrcBImmShift;
        ctrl.alu_op    = AluOpAdd;
      end
      StMemAdr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluOpAdd;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      StMemWb: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write  = 1'b1;
        ctrl.ior_d      = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBReg;
        ctrl.alu_op    = AluOpFunct;
      end
      StRwb: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SrcBReg;
        ctrl.alu_op        = AluOpSub;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PcSrcAluOut;
        ctrl.instr_done    = 1'b1;
      end
      StJump: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PcSrcJump;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register, opcode hold register and
// next-state logic; the control word comes from mc_output_decode.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit SUPPORT_JUMP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  state_e     state_q, state_d;
  logic [5:0] op_q;
  logic       illegal;
  ctrl_t      ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      // The instruction register may change after DECODE; MEMADR needs the original op.
      if (state_q == StDecode) op_q <= bus.op;
    end
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OpRtype:     state_d = StExec;
          OpLw, OpSw:  state_d = StMemAdr;
          OpBeq:       state_d = StBranch;
          OpJ: begin
            if (SUPPORT_JUMP) begin
              state_d = StJump;
            end else begin
              illegal = 1'b1;
              state_d = StFetch;
            end
          end
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        if (op_q == OpLw)      state_d = StMemRd;
        else if (op_q == OpSw) state_d = StMemWr;
        else                   state_d = StIdle;
      end
      StMemRd:  if (bus.mem_ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (bus.mem_ready) state_d = StFetch;
      StExec:   state_d = StRwb;
      StRwb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      default:  state_d = StIdle;
    endcase
  end

  mc_output_decode u_output_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.ior_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.state       = state_q;
  assign bus.instr_done  = ctrl.instr_done | illegal;
  assign bus.illegal_op  = illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus pushes the hand-computed per-cycle control vector,
// a negedge monitor pops and compares against both jump-enabled and jump-less DUTs.
module tb_multicycle_control;

  // {state[3:0], PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
  //  RegWrite, RegDst, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0], instr_done, illegal_op}
  typedef logic [21:0] vec_t;

  localparam vec_t E_IDLE       = {4'd0,  10'b0_0_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam vec_t E_FETCH_WAIT = {4'd1,  10'b0_0_0_1_0_0_0_0_0_0, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam vec_t E_FETCH_RDY  = {4'd1,  10'b1_0_0_1_0_1_0_0_0_0, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam vec_t E_DECODE     = {4'd2,  10'b0_0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 2'b00, 2'b00};
  localparam vec_t E_DECODE_ILL = {4'd2,  10'b0_0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 2'b00, 2'b11};
  localparam vec_t E_MEMADR     = {4'd3,  10'b0_0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam vec_t E_MEMRD      = {4'd4,  10'b0_0_1_1_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam vec_t E_MEMWB      = {4'd5,  10'b0_0_0_0_0_0_1_1_0_0, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam vec_t E_MEMWR_WAIT = {4'd6,  10'b0_0_1_0_1_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam vec_t E_MEMWR_RDY  = {4'd6,  10'b0_0_1_0_1_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam vec_t E_EXEC       = {4'd7,  10'b0_0_0_0_0_0_0_0_0_1, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam vec_t E_RWB        = {4'd8,  10'b0_0_0_0_0_0_0_1_1_0, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam vec_t E_BRANCH     = {4'd9,  10'b0_1_0_0_0_0_0_0_0_1, 2'b00, 2'b01, 2'b01, 2'b10};
  localparam vec_t E_JUMP       = {4'd10, 10'b1_0_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b10, 2'b10};

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op_v = '0;
  logic       mr_v = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  vec_t       q_j[$];
  vec_t       q_nj[$];
  vec_t       act_j, act_nj;

  multicycle_control_if bus_j ();
  multicycle_control_if bus_nj ();

  assign bus_j.op         = op_v;
  assign bus_j.mem_ready  = mr_v;
  assign bus_nj.op        = op_v;
  assign bus_nj.mem_ready = mr_v;

  multicycle_control #(.SUPPORT_JUMP(1'b1)) dut_j (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_j)
  );

  multicycle_control #(.SUPPORT_JUMP(1'b0)) dut_nj (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nj)
  );

  assign act_j = {bus_j.state, bus_j.PCWrite, bus_j.PCWriteCond, bus_j.IorD, bus_j.MemRead,
                  bus_j.MemWrite, bus_j.IRWrite, bus_j.MemtoReg, bus_j.RegWrite, bus_j.RegDst,
                  bus_j.ALUSrcA, bus_j.ALUSrcB, bus_j.ALUOp, bus_j.PCSource,
                  bus_j.instr_done, bus_j.illegal_op};
  assign act_nj = {bus_nj.state, bus_nj.PCWrite, bus_nj.PCWriteCond, bus_nj.IorD,
                   bus_nj.MemRead, bus_nj.MemWrite, bus_nj.IRWrite, bus_nj.MemtoReg,
                   bus_nj.RegWrite, bus_nj.RegDst, bus_nj.ALUSrcA, bus_nj.ALUSrcB,
                   bus_nj.ALUOp, bus_nj.PCSource, bus_nj.instr_done, bus_nj.illegal_op};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got state=%0d ctl=%05h, expected state=%0d ctl=%05h",
               name, cyc, act[21:18], act[17:0], exp[21:18], exp[17:0]);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    vec_t e;
    if (q_j.size() > 0) begin
      e = q_j.pop_front();
      check("dut_j", act_j, e);
    end
    if (q_nj.size() > 0) begin
      e = q_nj.pop_front();
      check("dut_nj", act_nj, e);
    end
  end

  task automatic step(input logic [5:0] o, input logic m, input vec_t e,
                      input bit chk_nj = 1'b0, input vec_t e_nj = '0);
    op_v = o;
    mr_v = m;
    q_j.push_back(e);
    if (chk_nj) q_nj.push_back(e_nj);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset held: all outputs zero regardless of inputs.
    step(OP_BAD, 1'b1, E_IDLE, 1'b1, E_IDLE);
    step(OP_R,   1'b0, E_IDLE, 1'b1, E_IDLE);
    rst_n = 1'b1;
    step(OP_BAD, 1'b1, E_IDLE, 1'b1, E_IDLE);

    // R-type: 1,2,7,8 then FETCH.
    step(OP_BAD, 1'b1, E_FETCH_RDY, 1'b1, E_FETCH_RDY);
    step(OP_R,   1'b1, E_DECODE,    1'b1, E_DECODE);
    step(OP_BAD, 1'b1, E_EXEC,      1'b1, E_EXEC);
    step(OP_BAD, 1'b1, E_RWB,       1'b1, E_RWB);

    // lw with three MEMRD wait cycles; op changes after DECODE to exercise the hold register.
    step(OP_BAD, 1'b1, E_FETCH_RDY);
    step(OP_LW,  1'b1, E_DECODE);
    step(OP_SW,  1'b1, E_MEMADR);
    step(OP_BAD, 1'b0, E_MEMRD);
    step(OP_BAD, 1'b0, E_MEMRD);
    step(OP_BAD, 1'b0, E_MEMRD);
    step(OP_BAD, 1'b1, E_MEMRD);
    step(OP_BAD, 1'b1, E_MEMWB);

    // sw then beq back to back.
    step(OP_BAD, 1'b1, E_FETCH_RDY);
    step(OP_SW,  1'b1, E_DECODE);
    step(OP_LW,  1'b1, E_MEMADR);
    step(OP_BAD, 1'b1, E_MEMWR_RDY);
    step(OP_BAD, 1'b1, E_FETCH_RDY);
    step(OP_BEQ, 1'b1, E_DECODE);
    step(OP_BAD, 1'b1, E_BRANCH);

    // Fetch wait, then illegal opcode.
    step(OP_BAD, 1'b0, E_FETCH_WAIT);
    step(OP_BAD, 1'b1, E_FETCH_RDY);
    step(OP_BAD, 1'b1, E_DECODE_ILL);

    // j: decoded by dut_j, illegal for dut_nj.
    step(OP_BAD, 1'b1, E_FETCH_RDY,  1'b1, E_FETCH_RDY);
    step(OP_J,   1'b1, E_DECODE,     1'b1, E_DECODE_ILL);
    step(OP_BAD, 1'b1, E_JUMP,       1'b1, E_FETCH_RDY);

    // sw stalled in MEMWR, then reset mid-wait.
    step(OP_BAD, 1'b1, E_FETCH_RDY);
    step(OP_SW,  1'b1, E_DECODE);
    step(OP_BAD, 1'b0, E_MEMADR);
    op_v = OP_BAD;
    mr_v = 1'b0;
    q_j.push_back(E_MEMWR_WAIT);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_memwr", act_j, E_IDLE);
    @(posedge clk);
    #1;
    step(OP_BAD, 1'b1, E_IDLE, 1'b1, E_IDLE);
    rst_n = 1'b1;
    step(OP_BAD, 1'b1, E_IDLE, 1'b1, E_IDLE);
    step(OP_BAD, 1'b1, E_FETCH_RDY, 1'b1, E_FETCH_RDY);
    step(OP_R,   1'b1, E_DECODE,    1'b1, E_DECODE);

    @(negedge clk);
    #1;
    n_cmp++;
    if (q_j.size() + q_nj.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0",
               q_j.size() + q_nj.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter SUPPORT_JUMP, default 1; 1 = opcode 6'b000010 (j) is decoded, 0 = j is treated as an illegal opcode.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-004 op  in  6  opcode from the instruction register; sampled only in DECODE.
REQ-005 mem_ready  in  1  memory handshake; 1 = the current read or write completes this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out  1 each  datapath enables.
REQ-007 MemtoReg, RegWrite, RegDst, ALUSrcA  out  1 each  datapath selects and enables.
REQ-008 ALUSrcB, ALUOp, PCSource  out  2 each  mux selects and ALU-control class (00 add, 01 sub, 10 funct).
REQ-009 state  out  4  current state encoding, for debug.
REQ-010 instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
REQ-011 illegal_op  out  1  one-cycle pulse in DECODE when op is unsupported.

Function
REQ-012 States and encodings SHALL be: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10.
REQ-013 Any output not listed for a state SHALL be 0 in that state.
REQ-014 IDLE: all outputs 0; the next state is always FETCH.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = mem_ready (combinational, Mealy).
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by op:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP (only when SUPPORT_JUMP=1)
  - any other op -> FETCH, with illegal_op=1 and instr_done=1.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD for op 100011, MEMWR for op 101011; op is held from DECODE in an internal register.
REQ-018 MEMRD: MemRead=1, IorD=1. Wait while mem_ready=0; go to MEMWB when mem_ready=1.
REQ-019 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1; next state FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1. Wait while mem_ready=0; when mem_ready=1, instr_done=1 and next state FETCH.
REQ-021 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state RWB.
REQ-022 RWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1; next state FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1; next state FETCH.
REQ-024 JUMP: PCWrite=1, PCSource=10, instr_done=1; next state FETCH.
REQ-025 Cycles per instruction with mem_ready tied to 1 SHALL be: R-type 4, lw 5, sw 4, beq 3, j 3; each wait cycle adds exactly 1.
REQ-026 MemRead and MemWrite SHALL never be 1 in the same cycle; RegWrite and any PC write SHALL never be 1 in the same cycle.
REQ-027 Any unreachable state encoding (11-15) SHALL go to IDLE on the next clock.

Reset
REQ-028 rst_n=0 SHALL force state=IDLE asynchronously; all outputs are 0 while reset is held, including mid-instruction and mid-wait.
REQ-029 On rst_n release the block SHALL spend one cycle in IDLE, then enter FETCH.

Structure
REQ-030 State encodings, opcode constants and the ALUOp/PCSource/ALUSrcB codes SHALL live in a shared package (mips_ctrl_pkg).
REQ-031 The block SHALL have one sub-module, mc_output_decode: a combinational state + mem_ready -> control-word decoder. The state register and next-state logic stay in multicycle_control.

Verification
REQ-032 Reset, then R-type (op=000000), mem_ready=1 -> states 0,1,2,7,8,1; RegWrite=1 and RegDst=1 only in RWB; instr_done pulses once.
REQ-033 lw with mem_ready=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles, MemRead=1 and IorD=1 throughout, then MEMWB with MemtoReg=1; 8 cycles total.
REQ-034 sw then beq back-to-back, mem_ready=1 -> MemWrite=1 for exactly 1 cycle; PCWriteCond=1 and ALUOp=01 in BRANCH; 4+3 cycles.
REQ-035 op=111111 in DECODE -> illegal_op=1 and instr_done=1 for 1 cycle, next state FETCH, RegWrite and MemWrite never asserted.
REQ-036 rst_n pulled low during a MEMWR wait -> MemWrite drops to 0 in the same cycle, state=0; after release, FETCH follows IDLE by exactly 1 cycle.
REQ-037 SUPPORT_JUMP=1, op=000010 -> JUMP state with PCWrite=1 and PCSource=10; with SUPPORT_JUMP=0 the same op -> illegal_op=1.
